// File: rtl/jpc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jpc_fetch_ctrl
// Description : Fetch sequencer sitting between jpc_pc, instruction memory
//               and decode. Drives jpc_pc's next_pc_I / en_I, issues
//               single-outstanding fetch requests at the current PC, holds
//               the returned word in a one-entry buffer for decode, and
//               advances the PC sequentially. Traps and branch redirects
//               override sequential flow and flush any in-flight or
//               buffered fetch.
//
// Ports       : clk, rst            - clock, synchronous active-high reset
//               pc_I                - current PC from jpc_pc
//               next_pc_O, pc_en_O  - PC update to jpc_pc (combinational)
//               imem_req_O/addr_O   - fetch request / address (= pc_I)
//               imem_ack_I/rdata_I  - fetch completion and data
//               instr_valid_O/instr_O/instr_pc_O/instr_ready_I
//                                   - buffered instruction handshake
//               redirect_I/pc_I     - taken branch / jump target
//               trap_I              - trap request (-> TRAP_VECTOR)
//               state_O             - debug state: IDLE=0 REQ=1 VALID=2
//
// Revision    : 1.0 - initial release
// ============================================================================
module jpc_fetch_ctrl #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0080
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc_I,
    output logic [ADDR_WIDTH-1:0] next_pc_O,
    output logic                  pc_en_O,
    output logic                  imem_req_O,
    output logic [ADDR_WIDTH-1:0] imem_addr_O,
    input  logic                  imem_ack_I,
    input  logic [31:0]           imem_rdata_I,
    output logic                  instr_valid_O,
    output logic [31:0]           instr_O,
    output logic [ADDR_WIDTH-1:0] instr_pc_O,
    input  logic                  instr_ready_I,
    input  logic                  redirect_I,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_I,
    input  logic                  trap_I,
    output logic [1:0]            state_O
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_req   = 2'd1;
    localparam logic [1:0] c_st_valid = 2'd2;

    // Word alignment: low two address bits are always cleared on a jump.
    localparam logic [ADDR_WIDTH-1:0] c_align_mask = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] c_pc_step    = ADDR_WIDTH'(4);

    logic [1:0]            r_state;
    logic                  r_instr_valid;
    logic [31:0]           r_instr;
    logic [ADDR_WIDTH-1:0] r_instr_pc;

    logic                  w_flush;
    logic [ADDR_WIDTH-1:0] w_target;
    logic [ADDR_WIDTH-1:0] w_pc_inc;

    // Trap wins over redirect when both are raised in the same cycle.
    assign w_flush  = trap_I | redirect_I;
    assign w_target = trap_I ? (TRAP_VECTOR & ~c_align_mask)
                             : (redirect_pc_I & ~c_align_mask);
    assign w_pc_inc = pc_I + c_pc_step;

    // The address is taken straight from jpc_pc; it cannot move while a
    // request is waiting because pc_en_O stays low in REQ until the ack.
    assign imem_addr_O = pc_I;

    // PC update and request are combinational so jpc_pc loads on the same
    // edge at which the controller changes state.
    always_comb begin
        next_pc_O  = w_pc_inc;
        pc_en_O    = 1'b0;
        imem_req_O = 1'b0;
        if (rst) begin
            next_pc_O = RESET_VECTOR;
        end else if (w_flush) begin
            // Request withdrawn this cycle; a coincident ack is dropped.
            next_pc_O = w_target;
            pc_en_O   = 1'b1;
        end else begin
            case (r_state)
                c_st_idle: begin
                    next_pc_O = RESET_VECTOR;
                    pc_en_O   = 1'b1;
                end
                c_st_req: begin
                    imem_req_O = 1'b1;
                    pc_en_O    = imem_ack_I;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
        end else if (w_flush) begin
            r_state       <= c_st_req;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_state <= c_st_req;
                end
                c_st_req: begin
                    if (imem_ack_I) begin
                        r_instr       <= imem_rdata_I;
                        r_instr_pc    <= pc_I;
                        r_instr_valid <= 1'b1;
                        r_state       <= c_st_valid;
                    end
                end
                c_st_valid: begin
                    if (instr_ready_I) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= c_st_req;
                    end
                end
                default: begin
                    r_state       <= c_st_idle;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign instr_valid_O = r_instr_valid;
    assign instr_O       = r_instr;
    assign instr_pc_O    = r_instr_pc;
    assign state_O       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_jpc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_jpc_fetch_ctrl
// Description : Self-checking bench for jpc_fetch_ctrl. Models jpc_pc as a
//               simple enable register and keeps a queue of instructions
//               expected at the decode handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jpc_fetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_q = 32'h5555_5550;
    logic [31:0] next_pc_O;
    logic        pc_en_O;
    logic        imem_req_O;
    logic [31:0] imem_addr_O;
    logic        imem_ack_I;
    logic [31:0] imem_rdata_I;
    logic        instr_valid_O;
    logic [31:0] instr_O;
    logic [31:0] instr_pc_O;
    logic        instr_ready_I;
    logic        redirect_I;
    logic [31:0] redirect_pc_I;
    logic        trap_I;
    logic [1:0]  state_O;

    int   total = 0;
    int   bad   = 0;
    ent_t exp_q[$];

    jpc_fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .pc_I          (pc_q),
        .next_pc_O     (next_pc_O),
        .pc_en_O       (pc_en_O),
        .imem_req_O    (imem_req_O),
        .imem_addr_O   (imem_addr_O),
        .imem_ack_I    (imem_ack_I),
        .imem_rdata_I  (imem_rdata_I),
        .instr_valid_O (instr_valid_O),
        .instr_O       (instr_O),
        .instr_pc_O    (instr_pc_O),
        .instr_ready_I (instr_ready_I),
        .redirect_I    (redirect_I),
        .redirect_pc_I (redirect_pc_I),
        .trap_I        (trap_I),
        .state_O       (state_O)
    );

    always #5 clk = ~clk;

    // jpc_pc model: plain enable register.
    always @(posedge clk) if (pc_en_O) pc_q <= next_pc_O;

    // Scoreboard: every accepted instruction must match the queue head.
    always @(negedge clk) begin
        #3;
        if (!rst && !trap_I && !redirect_I && instr_valid_O && instr_ready_I) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got pc=%h instr=%h want none", instr_pc_O, instr_O);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                if (instr_pc_O !== e.pc || instr_O !== e.instr) begin
                    bad++;
                    $display("FAIL sb_instr got pc=%h instr=%h want pc=%h instr=%h",
                             instr_pc_O, instr_O, e.pc, e.instr);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts in REQ at address a; ends in REQ (rel=1) or VALID with ready=0.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d,
                         input int waits, input int hold, input bit rel);
        for (int w = 0; w < waits; w++) begin
            #1;
            total++;
            if (imem_req_O !== 1'b1 || imem_addr_O !== a || pc_en_O !== 1'b0 || instr_valid_O !== 1'b0) begin
                bad++;
                $display("FAIL wait_req got req=%0b addr=%h en=%0b v=%0b want req=1 addr=%h en=0 v=0",
                         imem_req_O, imem_addr_O, pc_en_O, instr_valid_O, a);
            end
            step();
        end
        imem_ack_I = 1'b1; imem_rdata_I = d; #1;
        total++;
        if (imem_req_O !== 1'b1 || imem_addr_O !== a || pc_en_O !== 1'b1 || next_pc_O !== a + 32'd4) begin
            bad++;
            $display("FAIL ack_cycle got req=%0b addr=%h en=%0b npc=%h want req=1 addr=%h en=1 npc=%h",
                     imem_req_O, imem_addr_O, pc_en_O, next_pc_O, a, a + 32'd4);
        end
        exp_q.push_back({a, d});
        step();
        imem_ack_I = 1'b0; imem_rdata_I = 32'hDEAD_BEEF;
        for (int h = 0; h <= hold; h++) begin
            instr_ready_I = (h == hold) && rel; #1;
            total++;
            if (instr_valid_O !== 1'b1 || instr_O !== d || instr_pc_O !== a || imem_req_O !== 1'b0 ||
                pc_en_O !== 1'b0 || state_O !== 2'd2 || pc_q !== a + 32'd4) begin
                bad++;
                $display("FAIL valid_hold got v=%0b i=%h ipc=%h req=%0b en=%0b st=%0d pc=%h want v=1 i=%h ipc=%h req=0 en=0 st=2 pc=%h",
                         instr_valid_O, instr_O, instr_pc_O, imem_req_O, pc_en_O, state_O, pc_q, d, a, a + 32'd4);
            end
            if (h != hold || rel) step();
        end
        instr_ready_I = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++;
            if (pc_en_O !== 1'b0 || imem_req_O !== 1'b0 || instr_valid_O !== 1'b0 || state_O !== 2'd0 ||
                next_pc_O !== 32'h0 || imem_addr_O !== pc_q || instr_O !== 32'h0 || instr_pc_O !== 32'h0) begin
                bad++;
                $display("FAIL reset_state got en=%0b req=%0b v=%0b st=%0d npc=%h i=%h want en=0 req=0 v=0 st=0 npc=0 i=0",
                         pc_en_O, imem_req_O, instr_valid_O, state_O, next_pc_O, instr_O);
            end
        end
        rst = 1'b0; #1;
        total++;
        if (pc_en_O !== 1'b1 || next_pc_O !== 32'h0 || imem_req_O !== 1'b0) begin
            bad++;
            $display("FAIL boot_load got en=%0b npc=%h req=%0b want en=1 npc=0 req=0", pc_en_O, next_pc_O, imem_req_O);
        end
        step(); #1;
        total++;
        if (imem_req_O !== 1'b1 || imem_addr_O !== 32'h0 || pc_en_O !== 1'b0 || state_O !== 2'd1) begin
            bad++;
            $display("FAIL boot_req got req=%0b addr=%h en=%0b st=%0d want req=1 addr=0 en=0 st=1",
                     imem_req_O, imem_addr_O, pc_en_O, state_O);
        end
    endtask

    task automatic test_sequential();
        fetch(32'h0, 32'h13,  0, 0, 1'b1);
        fetch(32'h4, 32'h93,  0, 0, 1'b1);
        fetch(32'h8, 32'h113, 0, 0, 1'b1);
        #1;
        total++;
        if (imem_req_O !== 1'b1 || imem_addr_O !== 32'hC) begin
            bad++;
            $display("FAIL seq_next got req=%0b addr=%h want req=1 addr=0000000c", imem_req_O, imem_addr_O);
        end
    endtask

    task automatic test_wait_backpressure();
        fetch(32'hC, 32'h0000_0A13, 3, 5, 1'b1);
    endtask

    task automatic test_redirect();
        fetch(32'h10, 32'h0000_1113, 0, 0, 1'b0);
        redirect_I = 1'b1; redirect_pc_I = 32'h103; instr_ready_I = 1'b1; #1;
        total++;
        if (pc_en_O !== 1'b1 || next_pc_O !== 32'h100 || imem_req_O !== 1'b0) begin
            bad++;
            $display("FAIL redir_valid got en=%0b npc=%h req=%0b want en=1 npc=00000100 req=0", pc_en_O, next_pc_O, imem_req_O);
        end
        void'(exp_q.pop_front());
        step();
        redirect_I = 1'b0; instr_ready_I = 1'b0; #1;
        total++;
        if (instr_valid_O !== 1'b0 || imem_req_O !== 1'b1 || imem_addr_O !== 32'h100 || state_O !== 2'd1) begin
            bad++;
            $display("FAIL redir_resume got v=%0b req=%0b addr=%h st=%0d want v=0 req=1 addr=00000100 st=1",
                     instr_valid_O, imem_req_O, imem_addr_O, state_O);
        end
        // Redirect in REQ with a coincident ack: word must be discarded.
        redirect_I = 1'b1; redirect_pc_I = 32'h42; imem_ack_I = 1'b1; imem_rdata_I = 32'hBAD0_BAD0; #1;
        total++;
        if (pc_en_O !== 1'b1 || next_pc_O !== 32'h40 || imem_req_O !== 1'b0) begin
            bad++;
            $display("FAIL redir_req got en=%0b npc=%h req=%0b want en=1 npc=00000040 req=0", pc_en_O, next_pc_O, imem_req_O);
        end
        step();
        redirect_I = 1'b0; imem_ack_I = 1'b0; #1;
        total++;
        if (instr_valid_O !== 1'b0 || imem_req_O !== 1'b1 || imem_addr_O !== 32'h40) begin
            bad++;
            $display("FAIL redir_discard got v=%0b req=%0b addr=%h want v=0 req=1 addr=00000040",
                     instr_valid_O, imem_req_O, imem_addr_O);
        end
        fetch(32'h40, 32'h0000_4013, 0, 0, 1'b1);
    endtask

    task automatic test_trap_priority();
        trap_I = 1'b1; redirect_I = 1'b1; redirect_pc_I = 32'h200; #1;
        total++;
        if (pc_en_O !== 1'b1 || next_pc_O !== 32'h80 || imem_req_O !== 1'b0) begin
            bad++;
            $display("FAIL trap_prio got en=%0b npc=%h req=%0b want en=1 npc=00000080 req=0", pc_en_O, next_pc_O, imem_req_O);
        end
        step();
        trap_I = 1'b0; redirect_I = 1'b0;
        fetch(32'h80, 32'h0000_8013, 1, 0, 1'b1);
    endtask

    task automatic test_wrap_reset();
        redirect_I = 1'b1; redirect_pc_I = 32'hFFFF_FFFC;
        step();
        redirect_I = 1'b0;
        fetch(32'hFFFF_FFFC, 32'hFFFF_0013, 0, 0, 1'b1);
        fetch(32'h0, 32'h0000_0073, 0, 0, 1'b1);
        step();
        rst = 1'b1; #1;
        total++;
        if (imem_req_O !== 1'b0 || pc_en_O !== 1'b0 || next_pc_O !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid got req=%0b en=%0b npc=%h want req=0 en=0 npc=0", imem_req_O, pc_en_O, next_pc_O);
        end
        step();
        imem_ack_I = 1'b1; imem_rdata_I = 32'h1A7E_0001; #1;
        total++;
        if (state_O !== 2'd0 || imem_req_O !== 1'b0 || instr_valid_O !== 1'b0 || pc_q !== 32'h4) begin
            bad++;
            $display("FAIL rst_state got st=%0d req=%0b v=%0b pc=%h want st=0 req=0 v=0 pc=00000004",
                     state_O, imem_req_O, instr_valid_O, pc_q);
        end
        step();
        rst = 1'b0; imem_ack_I = 1'b0; #1;
        total++;
        if (instr_valid_O !== 1'b0 || pc_en_O !== 1'b1 || next_pc_O !== 32'h0 || state_O !== 2'd0) begin
            bad++;
            $display("FAIL rst_late_ack got v=%0b en=%0b npc=%h st=%0d want v=0 en=1 npc=0 st=0",
                     instr_valid_O, pc_en_O, next_pc_O, state_O);
        end
        step();
        fetch(32'h0, 32'h0000_0513, 0, 0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; imem_ack_I = 1'b0; imem_rdata_I = '0; instr_ready_I = 1'b0;
        redirect_I = 1'b0; redirect_pc_I = '0; trap_I = 1'b0;
        test_reset();
        test_sequential();
        test_wait_backpressure();
        test_redirect();
        test_trap_priority();
        test_wrap_reset();
        step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
